// File: rtl/variable_shift_ctrl.sv
// Iteration controller for the shift-over-0s/1s divider: owns the remaining-positions counter and issues shift/op steps.
// Define VSC_STATS_EN to add the iter_cnt and max_shift_seen status outputs.
module variable_shift_ctrl #(
    parameter int WIDTH     = 8,
    parameter int STEPS     = 8,
    parameter int MAX_SHIFT = 4,
    parameter int CNT_W     = 4,
    parameter int SH_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             op_init,
    input  logic [WIDTH-1:0] result,
    output logic [SH_W-1:0]  shift,
    output logic             op,
    output logic             step_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rem
`ifdef VSC_STATS_EN
    ,
    output logic [CNT_W-1:0] iter_cnt,
    output logic [SH_W-1:0]  max_shift_seen
`endif
);

    localparam int CW = (CNT_W > SH_W) ? CNT_W : SH_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic             op_q, op_d;
    logic             stepValid_q, stepValid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [SH_W-1:0]  matchIdx;
    logic [CW-1:0]    kExt, remExt, shiftExt;
    logic [SH_W-1:0]  stepShift;
    logic [CNT_W-1:0] stepRem;
    logic             remZero;
    logic             unusedResultBits;

    // Bits at MAX_SHIFT and above never take part in the step decision.
    assign unusedResultBits = ^result[WIDTH-1:MAX_SHIFT];

    always_comb begin
        matchIdx = SH_W'(MAX_SHIFT);
        for (int i = MAX_SHIFT - 1; i >= 0; i--) begin
            if (result[i] == op_q) begin
                matchIdx = SH_W'(i);
            end
        end
    end

    assign kExt      = CW'(matchIdx);
    assign remExt    = CW'(rem_q);
    assign shiftExt  = (kExt < remExt) ? kExt : remExt;
    assign stepShift = SH_W'(shiftExt);
    assign stepRem   = (remExt > shiftExt) ? CNT_W'(remExt - shiftExt - CW'(1)) : '0;
    assign remZero   = (rem_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            op_q        <= 1'b1;
            stepValid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            op_q        <= op_d;
            stepValid_q <= stepValid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rem_q       <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (remZero) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The final zero-shift step and the done pulse become visible together in the DONE cycle.
    always_comb begin
        shift_d     = shift_q;
        op_d        = op_q;
        stepValid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rem_d       = rem_q;
        if (flush) begin
            busy_d = 1'b0;
            rem_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_d  = CNT_W'(STEPS);
                        op_d   = op_init;
                        busy_d = 1'b1;
                    end
                end
                RUN: begin
                    stepValid_d = 1'b1;
                    op_d        = ~op_q;
                    if (remZero) begin
                        shift_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        shift_d = stepShift;
                        rem_d   = stepRem;
                    end
                end
                DONE: begin
                    busy_d = 1'b0;
                end
                default: begin
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    assign shift      = shift_q;
    assign op         = op_q;
    assign step_valid = stepValid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rem        = rem_q;

`ifdef VSC_STATS_EN
    logic [CNT_W-1:0] iterCnt_q, iterCnt_d;
    logic [SH_W-1:0]  maxShift_q, maxShift_d;

    // Statistics survive flush and done; only a new accepted start or reset clears them.
    always_comb begin
        iterCnt_d  = iterCnt_q;
        maxShift_d = maxShift_q;
        if (!flush) begin
            if (state_q == IDLE && start) begin
                iterCnt_d  = '0;
                maxShift_d = '0;
            end else if (state_q == RUN) begin
                iterCnt_d = iterCnt_q + CNT_W'(1);
                if (!remZero && stepShift > maxShift_q) begin
                    maxShift_d = stepShift;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iterCnt_q  <= '0;
            maxShift_q <= '0;
        end else begin
            iterCnt_q  <= iterCnt_d;
            maxShift_q <= maxShift_d;
        end
    end

    assign iter_cnt       = iterCnt_q;
    assign max_shift_seen = maxShift_q;
`endif

endmodule

// File: tb/tb_variable_shift_ctrl.sv
// Scoreboard bench for variable_shift_ctrl: expected steps are queued at start and popped on each step_valid.
module tb_variable_shift_ctrl;

    localparam int STEPS     = 8;
    localparam int MAX_SHIFT = 4;

    typedef struct {
        int   shift;
        logic op;
        int   rem;
    } step_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       flush;
    logic       op_init;
    logic [7:0] result;
    logic [2:0] shift;
    logic       op;
    logic       step_valid;
    logic       busy;
    logic       done;
    logic [3:0] rem;
`ifdef VSC_STATS_EN
    logic [3:0] iter_cnt;
    logic [2:0] max_shift_seen;
`endif

    step_t expQ[$];
    int    checkCount = 0;
    int    passCount  = 0;

    variable_shift_ctrl #(
        .WIDTH(8), .STEPS(STEPS), .MAX_SHIFT(MAX_SHIFT), .CNT_W(4), .SH_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .flush(flush),
        .op_init(op_init),
        .result(result),
        .shift(shift),
        .op(op),
        .step_valid(step_valid),
        .busy(busy),
        .done(done),
        .rem(rem)
`ifdef VSC_STATS_EN
        ,
        .iter_cnt(iter_cnt),
        .max_shift_seen(max_shift_seen)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushStep(input int sh, input logic o, input int r);
        step_t s;
        s.shift = sh;
        s.op    = o;
        s.rem   = r;
        expQ.push_back(s);
    endtask

    // Hand-derived sequence for op_init=1 with result low nibble all zeros.
    task automatic pushZeroSeq();
        pushStep(4, 1'b0, 3);
        pushStep(0, 1'b1, 2);
        pushStep(2, 1'b0, 0);
        pushStep(0, 1'b1, 0);
    endtask

    task automatic pushModel(input logic o, input logic [7:0] r);
        int   remM = STEPS;
        logic opM  = o;
        int   k;
        int   sh;
        while (remM != 0) begin
            k = MAX_SHIFT;
            for (int i = MAX_SHIFT - 1; i >= 0; i--) begin
                if (r[i] == opM) k = i;
            end
            sh   = (k < remM) ? k : remM;
            remM = (remM > sh) ? remM - sh - 1 : 0;
            opM  = ~opM;
            pushStep(sh, opM, remM);
        end
        opM = ~opM;
        pushStep(0, opM, 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".shift"}, 32'(shift), 32'd0);
        checkOutput({tag, ".op"}, 32'(op), 32'd1);
        checkOutput({tag, ".stepValid"}, 32'(step_valid), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".rem"}, 32'(rem), 32'd0);
`ifdef VSC_STATS_EN
        checkOutput({tag, ".iterCnt"}, 32'(iter_cnt), 32'd0);
        checkOutput({tag, ".maxShift"}, 32'(max_shift_seen), 32'd0);
`endif
    endtask

    task automatic checkStep(input string tag);
        step_t s;
        if (expQ.size() == 0) begin
            checkOutput({tag, ".unexpectedStep"}, 32'(expQ.size() != 0), 32'd1);
        end else begin
            s = expQ.pop_front();
            checkOutput({tag, ".shift"}, 32'(shift), 32'(s.shift));
            checkOutput({tag, ".op"}, 32'(op), 32'(s.op));
            checkOutput({tag, ".rem"}, 32'(rem), 32'(s.rem));
        end
    endtask

    task automatic applyStimulus(input logic o, input logic [7:0] r, input string tag);
        start   = 1'b1;
        op_init = o;
        result  = r;
        tick();
        start = 1'b0;
        checkOutput({tag, ".acceptBusy"}, 32'(busy), 32'd1);
        checkOutput({tag, ".acceptRem"}, 32'(rem), 32'(STEPS));
        checkOutput({tag, ".acceptOp"}, 32'(op), 32'(o));
        checkOutput({tag, ".acceptStepValid"}, 32'(step_valid), 32'd0);
`ifdef VSC_STATS_EN
        checkOutput({tag, ".iterCntClear"}, 32'(iter_cnt), 32'd0);
        checkOutput({tag, ".maxShiftClear"}, 32'(max_shift_seen), 32'd0);
`endif
    endtask

    task automatic runOp(input string tag);
        int cyc      = 0;
        bit seenDone = 1'b0;
        while (!seenDone && cyc < 40) begin
            tick();
            cyc++;
            if (step_valid) checkStep(tag);
            if (done) begin
                seenDone = 1'b1;
                checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'd1);
                checkOutput({tag, ".queueDrained"}, 32'(expQ.size()), 32'd0);
            end
        end
        checkOutput({tag, ".doneSeen"}, 32'(seenDone), 32'd1);
        if (seenDone) begin
            tick();
            checkOutput({tag, ".doneOneCycle"}, 32'(done), 32'd0);
            checkOutput({tag, ".busyAfterDone"}, 32'(busy), 32'd0);
            checkOutput({tag, ".stepValidAfterDone"}, 32'(step_valid), 32'd0);
        end
        expQ.delete();
    endtask

    initial begin
        logic       rndOp;
        logic [7:0] rndRes;

        rst     = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        op_init = 1'b0;
        result  = 8'h00;
        repeat (2) @(negedge clk);
        checkReset("rstHeld");
        rst = 1'b0;
        tick();
        checkReset("rstReleased");

        pushStep(0, 1'b0, 7);
        pushStep(1, 1'b1, 5);
        pushStep(0, 1'b0, 4);
        pushStep(1, 1'b1, 2);
        pushStep(0, 1'b0, 1);
        pushStep(1, 1'b1, 0);
        pushStep(0, 1'b0, 0);
        applyStimulus(1'b1, 8'h01, "alt01");
        runOp("alt01");

        pushZeroSeq();
        applyStimulus(1'b1, 8'h00, "zeros");
        runOp("zeros");
`ifdef VSC_STATS_EN
        checkOutput("zeros.iterCnt", 32'(iter_cnt), 32'd4);
        checkOutput("zeros.maxShift", 32'(max_shift_seen), 32'd4);
`endif

        pushZeroSeq();
        applyStimulus(1'b1, 8'hF0, "upperIgnored");
        runOp("upperIgnored");

        pushZeroSeq();
        applyStimulus(1'b1, 8'h00, "flush");
        tick();
        checkStep("flush");
        flush   = 1'b1;
        start   = 1'b1;
        op_init = 1'b0;
        tick();
        flush = 1'b0;
        start = 1'b0;
        checkOutput("flush.busy", 32'(busy), 32'd0);
        checkOutput("flush.stepValid", 32'(step_valid), 32'd0);
        checkOutput("flush.done", 32'(done), 32'd0);
        checkOutput("flush.rem", 32'(rem), 32'd0);
        checkOutput("flush.opHold", 32'(op), 32'd0);
        checkOutput("flush.shiftHold", 32'(shift), 32'd4);
        expQ.delete();
        tick();
        checkOutput("flush.startDropped", 32'(busy), 32'd0);
        checkOutput("flush.noDone", 32'(done), 32'd0);
        pushZeroSeq();
        applyStimulus(1'b1, 8'h00, "afterFlush");
        runOp("afterFlush");

        pushZeroSeq();
        applyStimulus(1'b1, 8'h00, "startBusy");
        tick();
        checkStep("startBusy");
        start   = 1'b1;
        op_init = 1'b0;
        tick();
        start = 1'b0;
        checkStep("startBusy");
        runOp("startBusy");

        pushZeroSeq();
        applyStimulus(1'b1, 8'h00, "midRst");
        tick();
        checkStep("midRst");
        #2 rst = 1'b1;
        #1 checkReset("midRst");
        @(negedge clk);
        checkOutput("midRst.noDone1", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("midRst.noDone2", 32'(done), 32'd0);
        rst = 1'b0;
        expQ.delete();
        tick();
        checkOutput("midRst.idleBusy", 32'(busy), 32'd0);
        checkOutput("midRst.idleDone", 32'(done), 32'd0);
        checkOutput("midRst.idleStepValid", 32'(step_valid), 32'd0);

        for (int n = 0; n < 4; n++) begin
            rndOp  = 1'($urandom_range(0, 1));
            rndRes = 8'($urandom_range(0, 255));
            pushModel(rndOp, rndRes);
            applyStimulus(rndOp, rndRes, "random");
            runOp("random");
        end

        checkOutput("finalQueue", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
